// File: rtl/muldiv_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide sequencer.
// master: EX stage / hazard logic (drives issue, operands, flush, mfhi/mflo reads)
// slave : muldiv_sequencer (returns busy, done, stall and the HI/LO registers)
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             abort;
    logic             hi_rd;
    logic             lo_rd;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, abort, hi_rd, lo_rd,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, abort, hi_rd, lo_rd,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu unit next to the EX-stage ALU; owns HI/LO.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   bus (slave)   start/op/rs_val/rt_val issue, abort flush, hi_rd/lo_rd reads;
//                 busy/done/stall status, hi/lo result registers
//
// state | meaning
// IDLE  | no operation, waiting for start
// CALC  | WIDTH iteration steps
// FIX   | sign correction, HI/LO written on exit
// DONE  | one-cycle done pulse; a new start is accepted here
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   mag_b_q;
    // mult: {partial product high, remaining multiplier bits}
    // div : low half holds the dividend, shifting into quotient bits
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic               sign_a_q, sign_b_q, is_div_q, b_zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               capture, last_step;
    logic               sign_a_in, sign_b_in;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign capture   = (state_q == IDLE || state_q == DONE) && bus.start && !bus.abort;
    assign last_step = (state_q == CALC) && (cnt_q == CW'(WIDTH - 1));

    // Sign flags are only set for the signed ops, so unsigned ops never negate.
    assign sign_a_in = ~bus.op[0] & bus.rs_val[WIDTH-1];
    assign sign_b_in = ~bus.op[0] & bus.rt_val[WIDTH-1];
    assign mag_a_in  = sign_a_in ? -bus.rs_val : bus.rs_val;
    assign mag_b_in  = sign_b_in ? -bus.rt_val : bus.rt_val;

    // Shift-add: add multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right keeping the carry.
    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
    assign mul_next = {sum, acc_q[WIDTH-1:1]};

    // Restoring divide: bring in the next dividend bit, subtract if it fits.
    assign trial    = {rem_q, acc_q[WIDTH-1]};
    assign fits     = trial >= {1'b0, mag_b_q};
    assign rem_next = fits ? WIDTH'(trial - {1'b0, mag_b_q}) : trial[WIDTH-1:0];
    assign div_next = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], fits};

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    // Divide by zero: the restoring loop leaves |dividend| as remainder, so
    // re-applying the dividend sign returns rs_val; only the quotient is forced.
    assign quo_fix  = b_zero_q ? '1 :
                      ((sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = sign_a_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (capture) state_d = CALC;
            CALC:    if (last_step) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = capture ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                mag_a_q  <= mag_a_in;
                mag_b_q  <= mag_b_in;
                sign_a_q <= sign_a_in;
                sign_b_q <= sign_b_in;
                is_div_q <= bus.op[1];
                b_zero_q <= (bus.rt_val == '0);
                cnt_q    <= '0;
                rem_q    <= '0;
                acc_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a_in : mag_b_in)};
            end else if (state_q == CALC && !bus.abort) begin
                cnt_q <= cnt_q + CW'(1);
                if (is_div_q) begin
                    acc_q <= div_next;
                    rem_q <= rem_next;
                end else begin
                    acc_q <= mul_next;
                end
            end
            if (state_q == FIX && !bus.abort) begin
                if (is_div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.busy  = (state_q == CALC) || (state_q == FIX);
    assign bus.done  = (state_q == DONE);
    assign bus.stall = bus.busy & (bus.start | bus.hi_rd | bus.lo_rd);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
